// File: rtl/bus_pkg.sv
// Shared definitions for the core memory bus and the bus_ram responder.
package bus_pkg;

    localparam int BUS_WORD_BYTES = 4;
    localparam int BUS_BE_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_ram_state_t;

endpackage

// File: rtl/bus_if.sv
// Core memory bus: master drives request and payload, slave answers with a one-cycle ack.
interface bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (output req, we, addr, wdata, be, input rdata, ack, err);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack, err);
endinterface

// File: rtl/bus_ram_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
module bus_ram_array
    import bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [BUS_BE_W-1:0] be,
    input  logic [IDX_W-1:0]    idx,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = mem[idx];
    end

    // Contents are deliberately left unreset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BUS_BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_ram.sv
// bus_ram: slave-side RAM on bus_if with WAIT_CYCLES wait states and a one-cycle ack.
// Define BUS_RAM_ERR_EN to flag misaligned/out-of-range accesses on err instead of wrapping.
module bus_ram
    import bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input logic  clk,
    input logic  rst,
    bus_if.slave bus
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * BUS_WORD_BYTES);

    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("bus_ram: DEPTH_WORDS must be a power of two >= 4");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("bus_ram: WAIT_CYCLES must be in 0..15");
    end
    if ((BASE_ADDR & (SPAN - 32'd1)) != 32'd0) begin : g_bad_base
        $error("bus_ram: BASE_ADDR must be aligned to the RAM size");
    end

    bus_ram_state_t      state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [BUS_BE_W-1:0] be_q, be_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [IDX_W-1:0]    idx;
    logic [31:0]         arr_rdata;
    logic                err_cond;
    logic                arr_we;
    logic                rd_fire;

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    be_d    = bus.be;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        // The array read register samples on the edge entering RESP; with no wait
        // states that edge is the capture edge, so IDLE must look at the live bus.
        idx = (state_q == IDLE) ? word_idx(bus.addr) : word_idx(addr_q);
`ifdef BUS_RAM_ERR_EN
        err_cond = (addr_q[1:0] != 2'b00) || ((addr_q - BASE_ADDR) >= SPAN);
`else
        err_cond = 1'b0;
`endif
        arr_we  = (state_q == RESP) && we_q && !err_cond;
        rd_fire = (state_q == RESP) && !we_q && !err_cond;
        // Array output is only meaningful during RESP; rdata_q keeps it afterwards.
        rdata_d = rd_fire ? arr_rdata : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= '0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    bus_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (be_q),
        .idx   (idx),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    assign bus.rdata = rdata_d;
    assign bus.ack   = (state_q == RESP);
    assign bus.err   = (state_q == RESP) && err_cond;

endmodule

// File: tb/tb_bus_ram.sv
// Self-checking bench for bus_ram: one instance with one wait state, one with none.
module tb_bus_ram;
    import bus_pkg::*;

`ifdef BUS_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } stim_t;
    typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
    typedef struct { int lat; logic err; logic [31:0] rdata; logic ack_after; logic err_after; } obs_t;

    logic clk = 1'b0;
    logic rst;

    bus_if b0 ();
    bus_if b1 ();

    bus_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    bus_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    exp_t        sbq[$];
    logic [31:0] mdl [2][1024];
    logic [31:0] last_rd [2];
    int          total = 0;
    int          bad   = 0;
    stim_t       idle_s = '{1'b0, 32'h0, 32'h0, 4'h0};

    function automatic logic ack_of(input int sel);
        return (sel == 1) ? b1.ack : b0.ack;
    endfunction
    function automatic logic err_of(input int sel);
        return (sel == 1) ? b1.err : b0.err;
    endfunction
    function automatic logic [31:0] rdata_of(input int sel);
        return (sel == 1) ? b1.rdata : b0.rdata;
    endfunction

    task automatic drive(input int sel, input logic req, input stim_t s);
        if (sel == 1) begin
            b1.req = req; b1.we = s.we; b1.addr = s.addr; b1.wdata = s.wdata; b1.be = s.be;
        end else begin
            b0.req = req; b0.we = s.we; b0.addr = s.addr; b0.wdata = s.wdata; b0.be = s.be;
        end
    endtask

    // Updates the reference model, queues the expected response and drives the request.
    task automatic push_txn(input int sel, input stim_t s);
        exp_t e;
        logic er;
        int   idx;
        er  = ERR_EN && ((s.addr[1:0] != 2'b00) || (s.addr >= 32'h1000));
        idx = int'(s.addr[11:2]);
        if (!s.we && !er) last_rd[sel] = mdl[sel][idx];
        if (s.we && !er)
            for (int i = 0; i < 4; i++)
                if (s.be[i]) mdl[sel][idx][8*i +: 8] = s.wdata[8*i +: 8];
        e.rdata = last_rd[sel];
        e.err   = er;
        e.lat   = (sel == 1) ? 1 : 0;
        sbq.push_back(e);
        drive(sel, 1'b1, s);
    endtask

    // lat counts falling edges after the capture edge until ack is seen (-1: never).
    task automatic run_txn(input int sel, input stim_t s, output obs_t o);
        o = '{-1, 1'b0, 32'h0, 1'b0, 1'b0};
        push_txn(sel, s);
        @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack_of(sel) === 1'b1) begin
                o.lat = c; o.err = err_of(sel); o.rdata = rdata_of(sel);
                break;
            end
        end
        drive(sel, 1'b0, idle_s);
        @(negedge clk);
        o.ack_after = ack_of(sel);
        o.err_after = err_of(sel);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            total++; if (ack_of(s) !== 1'b0) begin bad++; $display("FAIL reset_ack[%0d]: got %b want 0", s, ack_of(s)); end
            total++; if (err_of(s) !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", s, err_of(s)); end
            total++; if (rdata_of(s) !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", s, rdata_of(s)); end
        end
        total++; if (dut1.state_q !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", dut1.state_q); end
        total++; if (dut1.cnt_q !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", dut1.cnt_q); end
    endtask

    task automatic test_basic();
        stim_t s[2];
        obs_t  o;
        exp_t  e;
        s[0] = '{1'b1, 32'h10, 32'hCAFE_F00D, 4'hF};
        s[1] = '{1'b0, 32'h10, 32'h0, 4'h0};
        foreach (s[i]) begin
            run_txn(1, s[i], o);
            e = sbq.pop_front();
            total++; if (o.lat !== e.lat) begin bad++; $display("FAIL basic_lat[%0d]: got %0d want %0d", i, o.lat, e.lat); end
            total++; if (o.err !== e.err) begin bad++; $display("FAIL basic_err[%0d]: got %b want %b", i, o.err, e.err); end
            total++; if (o.rdata !== e.rdata) begin bad++; $display("FAIL basic_rdata[%0d]: got %h want %h", i, o.rdata, e.rdata); end
            total++; if (o.ack_after !== 1'b0) begin bad++; $display("FAIL basic_single_ack[%0d]: got %b want 0", i, o.ack_after); end
        end
        total++; if (o.rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL basic_readback: got %h want cafef00d", o.rdata); end
    endtask

    task automatic test_partial();
        stim_t s[5];
        obs_t  o;
        exp_t  e;
        logic [31:0] merged;
        s[0] = '{1'b1, 32'h30, 32'h1122_3344, 4'hF};
        s[1] = '{1'b1, 32'h30, 32'hAABB_CCDD, 4'b0101};
        s[2] = '{1'b0, 32'h30, 32'h0, 4'h0};
        s[3] = '{1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0000};
        s[4] = '{1'b0, 32'h30, 32'h0, 4'hF};
        merged = 32'h0;
        foreach (s[i]) begin
            run_txn(1, s[i], o);
            e = sbq.pop_front();
            total++; if (o.lat !== e.lat) begin bad++; $display("FAIL partial_lat[%0d]: got %0d want %0d", i, o.lat, e.lat); end
            total++; if (o.rdata !== e.rdata) begin bad++; $display("FAIL partial_rdata[%0d]: got %h want %h", i, o.rdata, e.rdata); end
            total++; if (o.ack_after !== 1'b0) begin bad++; $display("FAIL partial_single_ack[%0d]: got %b want 0", i, o.ack_after); end
            if (i == 2) merged = o.rdata;
        end
        total++; if (merged !== 32'h11BB_33DD) begin bad++; $display("FAIL partial_merge: got %h want 11bb33dd", merged); end
        total++; if (o.rdata !== 32'h11BB_33DD) begin bad++; $display("FAIL partial_be0_nowrite: got %h want 11bb33dd", o.rdata); end
    endtask

    task automatic test_early_drop();
        obs_t o;
        exp_t e;
        int   lat;
        lat = -1;
        push_txn(1, '{1'b1, 32'h50, 32'h5555_AAAA, 4'hF});
        @(posedge clk);
        @(negedge clk);
        if (b1.ack === 1'b1) lat = 0;
        drive(1, 1'b0, idle_s);
        for (int c = 1; c < 20 && lat < 0; c++) begin
            @(negedge clk);
            if (b1.ack === 1'b1) lat = c;
        end
        e = sbq.pop_front();
        total++; if (lat !== e.lat) begin bad++; $display("FAIL early_drop_lat: got %0d want %0d", lat, e.lat); end
        @(negedge clk);
        run_txn(1, '{1'b0, 32'h50, 32'h0, 4'h0}, o);
        e = sbq.pop_front();
        total++; if (o.rdata !== 32'h5555_AAAA) begin bad++; $display("FAIL early_drop_data: got %h want 5555aaaa", o.rdata); end
        total++; if (o.rdata !== e.rdata) begin bad++; $display("FAIL early_drop_model: got %h want %h", o.rdata, e.rdata); end
    endtask

    task automatic test_addr_map();
        stim_t s[7];
        obs_t  o;
        exp_t  e;
        logic [31:0] want_final;
        s[0] = '{1'b1, 32'h0000_0000, 32'h5A5A_5A5A, 4'hF};
        s[1] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0};
        s[2] = '{1'b1, 32'h0000_1000, 32'h600D_D00D, 4'hF};
        s[3] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0};
        s[4] = '{1'b1, 32'h0000_0002, 32'h1234_5678, 4'hF};
        s[5] = '{1'b0, 32'h0000_1000, 32'h0, 4'h0};
        s[6] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0};
        want_final = ERR_EN ? 32'h5A5A_5A5A : 32'h1234_5678;
        foreach (s[i]) begin
            run_txn(1, s[i], o);
            e = sbq.pop_front();
            total++; if (o.lat !== e.lat) begin bad++; $display("FAIL map_lat[%0d]: got %0d want %0d", i, o.lat, e.lat); end
            total++; if (o.err !== e.err) begin bad++; $display("FAIL map_err[%0d]: got %b want %b", i, o.err, e.err); end
            total++; if (o.rdata !== e.rdata) begin bad++; $display("FAIL map_rdata[%0d]: got %h want %h", i, o.rdata, e.rdata); end
            total++; if (o.err_after !== 1'b0) begin bad++; $display("FAIL map_err_idle[%0d]: got %b want 0", i, o.err_after); end
        end
        total++; if (o.rdata !== want_final) begin bad++; $display("FAIL map_final: got %h want %h", o.rdata, want_final); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        int   n, last;
        for (int i = 0; i < 4; i++) begin
            run_txn(0, '{1'b1, 32'h40 + 32'(4*i), 32'hA0B0_0000 + 32'(i), 4'hF}, o);
            e = sbq.pop_front();
            total++; if (o.lat !== e.lat) begin bad++; $display("FAIL b2b_preload_lat[%0d]: got %0d want %0d", i, o.lat, e.lat); end
        end
        n = 0;
        last = -100;
        push_txn(0, '{1'b0, 32'h40, 32'h0, 4'h0});
        @(posedge clk);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (b0.ack === 1'b1) begin
                total++;
                if (n >= 4) begin
                    bad++; $display("FAIL b2b_extra_ack: got ack %0d at cycle %0d want 4 total", n + 1, c);
                end else begin
                    e = sbq.pop_front();
                    if (b0.rdata !== e.rdata) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", n, b0.rdata, e.rdata); end
                    if (n > 0) begin
                        total++; if (c - last !== 2) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 2", n, c - last); end
                    end
                end
                last = c;
                n++;
                if (n < 4) push_txn(0, '{1'b0, 32'h40 + 32'(4*n), 32'h0, 4'h0});
                else drive(0, 1'b0, idle_s);
            end
        end
        drive(0, 1'b0, idle_s);
        total++; if (n !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", n); end
        while (sbq.size() > 0) void'(sbq.pop_front());
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        int   acks;
        run_txn(1, '{1'b1, 32'h20, 32'h0, 4'hF}, o);
        e = sbq.pop_front();
        total++; if (o.lat !== e.lat) begin bad++; $display("FAIL rst_mid_preload_lat: got %0d want %0d", o.lat, e.lat); end
        drive(1, 1'b1, '{1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF});
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (b1.ack !== 1'b0) begin bad++; $display("FAIL rst_mid_ack: got %b want 0", b1.ack); end
        total++; if (dut1.state_q !== IDLE) begin bad++; $display("FAIL rst_mid_state: got %0d want IDLE", dut1.state_q); end
        drive(1, 1'b0, idle_s);
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (b1.ack === 1'b1) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL rst_mid_no_ack: got %0d acks want 0", acks); end
        run_txn(1, '{1'b0, 32'h20, 32'h0, 4'h0}, o);
        e = sbq.pop_front();
        total++; if (o.rdata !== 32'h0) begin bad++; $display("FAIL rst_mid_no_write: got %h want 0", o.rdata); end
        total++; if (o.lat !== e.lat) begin bad++; $display("FAIL rst_mid_read_lat: got %0d want %0d", o.lat, e.lat); end
    endtask

    initial begin
        rst = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        drive(0, 1'b0, idle_s);
        drive(1, 1'b0, idle_s);
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_basic();
        test_partial();
        test_early_drop();
        test_addr_map();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
